bcd_updown_counter_nd: RTL and testbench

- Parametrised N-digit BCD counter; next generation of the 2-digit minutes/seconds up-counter.
- Adds per-digit limits, up/down direction, synchronous preload and registered carry/borrow outputs.
- Used for stopwatch and countdown timers: MM:SS, HH:MM, or a plain 0-99 counter.
- Counting steps come from an external one-pulse-per-tick enable, typically from the clock divider.

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_digit_cell.sv | 47 ++++
 rtl/bcd_updown_counter_nd.sv | 100 ++++++++++
 tb/tb_bcd_updown_counter_nd.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, constants and load clamp helper
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    function automatic bcd_digit_t clamp_digit(input bcd_digit_t value, input bcd_digit_t limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD digit register with limit-aware inc/dec/load
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  bcd_digit_t limit,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  bcd_digit_t init,
    output bcd_digit_t digit,
    output logic       at_limit,
    output logic       at_zero
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;
    bcd_digit_t limit_eff;

    // A limit above 9 would let the digit leave BCD range, so cap it here.
    assign limit_eff = (limit > BCD_MAX) ? BCD_MAX : limit;

    assign at_limit = (digit_q == limit_eff);
    assign at_zero  = (digit_q == '0);
    assign digit    = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = clamp_digit(init, limit_eff);
        end else if (inc) begin
            digit_d = at_limit ? '0 : digit_q + 4'd1;
        end else if (dec) begin
            digit_d = at_zero ? limit_eff : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_updown_counter_nd.sv
// rtl/bcd_updown_counter_nd.sv - N-digit BCD up/down counter; BCD_COUNTER_SATURATE_EN selects saturate instead of wrap
module bcd_updown_counter_nd
    import bcd_pkg::*;
#(
    parameter int                      NUM_DIGITS   = 2,
    parameter logic [4*NUM_DIGITS-1:0] DIGIT_LIMITS = {4'd5, 4'd9}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    dir,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] init_value,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    carry_out,
    output logic                    borrow_out,
    output logic                    at_max,
    output logic                    at_zero
);

    logic [NUM_DIGITS-1:0] lim_v;
    logic [NUM_DIGITS-1:0] zero_v;
    logic [NUM_DIGITS-1:0] inc_v;
    logic [NUM_DIGITS-1:0] dec_v;

    logic step_up;
    logic step_dn;
    logic move_up;
    logic move_dn;

    logic carry_q;
    logic carry_d;
    logic borrow_q;
    logic borrow_d;

    assign at_max  = &lim_v;
    assign at_zero = &zero_v;

    assign step_up = en & ~dir & ~load;
    assign step_dn = en &  dir & ~load;

`ifdef BCD_COUNTER_SATURATE_EN
    assign move_up = step_up & ~at_max;
    assign move_dn = step_dn & ~at_zero;
`else
    assign move_up = step_up;
    assign move_dn = step_dn;
`endif

    // Digit i moves only when every lower digit is at its wrap point.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            inc_v[i] = move_up;
            dec_v[i] = move_dn;
            for (int j = 0; j < i; j++) begin
                inc_v[i] = inc_v[i] & lim_v[j];
                dec_v[i] = dec_v[i] & zero_v[j];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_digit_cell u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .limit    (DIGIT_LIMITS[4*g +: 4]),
                .inc      (inc_v[g]),
                .dec      (dec_v[g]),
                .load     (load),
                .init     (init_value[4*g +: 4]),
                .digit    (value[4*g +: 4]),
                .at_limit (lim_v[g]),
                .at_zero  (zero_v[g])
            );
        end
    endgenerate

    // Pulses fire on the step itself, so a blocked saturating step still flags.
    always_comb begin
        carry_d  = step_up & at_max;
        borrow_d = step_dn & at_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_bcd_updown_counter_nd.sv
// tb/tb_bcd_updown_counter_nd.sv - scoreboard bench for 2-digit (59) and 3-digit (299) counters
module tb_bcd_updown_counter_nd;

`ifdef BCD_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int MAX_A = 59;
    localparam int MAX_B = 299;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        en_a, dir_a, load_a;
    logic [7:0]  init_a, value_a;
    logic        carry_a, borrow_a, at_max_a, at_zero_a;
    logic        en_b, dir_b, load_b;
    logic [11:0] init_b, value_b;
    logic        carry_b, borrow_b, at_max_b, at_zero_b;

    bcd_updown_counter_nd #(.NUM_DIGITS(2), .DIGIT_LIMITS(8'h59)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .dir(dir_a), .load(load_a),
        .init_value(init_a), .value(value_a), .carry_out(carry_a),
        .borrow_out(borrow_a), .at_max(at_max_a), .at_zero(at_zero_a)
    );

    bcd_updown_counter_nd #(.NUM_DIGITS(3), .DIGIT_LIMITS(12'h299)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .dir(dir_b), .load(load_b),
        .init_value(init_b), .value(value_b), .carry_out(carry_b),
        .borrow_out(borrow_b), .at_max(at_max_b), .at_zero(at_zero_b)
    );

    typedef struct {
        bit          sel;
        logic [11:0] value;
        logic        carry;
        logic        borrow;
        logic        amax;
        logic        azero;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   idx_a  = 0;
    int   idx_b  = 0;
    int   ncarry;

    function automatic logic [11:0] to_bcd(input int n);
        logic [11:0] r;
        r[11:8] = 4'((n / 100) % 10);
        r[7:4]  = 4'((n / 10) % 10);
        r[3:0]  = 4'(n % 10);
        return r;
    endfunction

    function automatic int clamp_int(input logic [3:0] v, input int lim);
        return (int'(v) > lim) ? lim : int'(v);
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Models the count as a plain integer 0..MAX; both limit sets are decimal-contiguous.
    task automatic step(input bit sel, input bit l, input bit e, input bit d,
                        input logic [11:0] init, input string tag);
        exp_t x;
        exp_t y;
        int   idx;
        int   mx;
        idx      = sel ? idx_b : idx_a;
        mx       = sel ? MAX_B : MAX_A;
        x.carry  = 1'b0;
        x.borrow = 1'b0;
        if (l) begin
            if (sel) idx = clamp_int(init[11:8], 2) * 100 + clamp_int(init[7:4], 9) * 10 + clamp_int(init[3:0], 9);
            else     idx = clamp_int(init[7:4], 5) * 10 + clamp_int(init[3:0], 9);
        end else if (e && !d) begin
            if (idx == mx) begin
                x.carry = 1'b1;
                idx = SAT ? mx : 0;
            end else begin
                idx++;
            end
        end else if (e && d) begin
            if (idx == 0) begin
                x.borrow = 1'b1;
                idx = SAT ? 0 : mx;
            end else begin
                idx--;
            end
        end
        if (sel) idx_b = idx; else idx_a = idx;
        x.sel   = sel;
        x.value = to_bcd(idx);
        x.amax  = (idx == mx);
        x.azero = (idx == 0);
        x.tag   = tag;
        sb.push_back(x);

        en_a = 1'b0; dir_a = 1'b0; load_a = 1'b0; init_a = '0;
        en_b = 1'b0; dir_b = 1'b0; load_b = 1'b0; init_b = '0;
        if (sel) begin
            en_b = e; dir_b = d; load_b = l; init_b = init;
        end else begin
            en_a = e; dir_a = d; load_a = l; init_a = init[7:0];
        end
        @(posedge clk);
        @(negedge clk);

        y = sb.pop_front();
        if (y.sel) begin
            check({y.tag, ".value"},  value_b,         y.value);
            check({y.tag, ".carry"},  12'(carry_b),    12'(y.carry));
            check({y.tag, ".borrow"}, 12'(borrow_b),   12'(y.borrow));
            check({y.tag, ".at_max"}, 12'(at_max_b),   12'(y.amax));
            check({y.tag, ".at_zero"},12'(at_zero_b),  12'(y.azero));
        end else begin
            check({y.tag, ".value"},  {4'h0, value_a}, y.value);
            check({y.tag, ".carry"},  12'(carry_a),    12'(y.carry));
            check({y.tag, ".borrow"}, 12'(borrow_a),   12'(y.borrow));
            check({y.tag, ".at_max"}, 12'(at_max_a),   12'(y.amax));
            check({y.tag, ".at_zero"},12'(at_zero_a),  12'(y.azero));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en_a = 1'b0; dir_a = 1'b0; load_a = 1'b0; init_a = '0;
        en_b = 1'b0; dir_b = 1'b0; load_b = 1'b0; init_b = '0;
        repeat (2) @(negedge clk);
        check("rst.value_a",  {4'h0, value_a}, 12'h000);
        check("rst.carry_a",  12'(carry_a),    12'd0);
        check("rst.borrow_a", 12'(borrow_a),   12'd0);
        check("rst.at_zero_a",12'(at_zero_a),  12'd1);
        check("rst.value_b",  value_b,         12'h000);
        rst_n = 1'b1;
        @(negedge clk);

        // 60 up-steps: 01..59 then 00 with exactly one carry.
        ncarry = 0;
        for (int i = 0; i < 60; i++) begin
            step(0, 0, 1, 0, 12'h000, $sformatf("up%0d", i));
            if (carry_a) ncarry++;
        end
        check("carry_once", 12'(ncarry), 12'd1);
        step(0, 0, 0, 0, 12'h000, "hold_after_wrap");

        step(0, 1, 0, 0, 12'h059, "load59");
        step(0, 0, 1, 1, 12'h000, "down58");
        step(0, 1, 0, 0, 12'h000, "load00");
        step(0, 0, 1, 1, 12'h000, "down_wrap");
        step(0, 0, 0, 0, 12'h000, "hold_after_borrow");
        step(0, 1, 0, 0, 12'h079, "load79_clamp");
        step(0, 1, 1, 0, 12'h012, "load_over_en");
        step(0, 1, 1, 1, 12'h059, "load_over_en_dn");
        step(0, 0, 1, 0, 12'h000, "up_at_max");
        step(0, 1, 0, 0, 12'h000, "load00_b");
        step(0, 0, 1, 1, 12'h000, "down_at_zero");

        step(1, 1, 0, 0, 12'h299, "b_load299");
        step(1, 0, 1, 0, 12'h000, "b_up_wrap");
        step(1, 1, 0, 0, 12'h150, "b_load150");
        step(1, 0, 1, 0, 12'h000, "b_up151");
        step(1, 0, 1, 1, 12'h000, "b_dn150");
        step(1, 0, 1, 0, 12'h000, "b_up151b");
        step(1, 1, 0, 0, 12'h199, "b_load199");
        step(1, 0, 1, 0, 12'h000, "b_ripple200");
        step(1, 0, 1, 1, 12'h000, "b_ripple199");
        step(1, 1, 0, 0, 12'h000, "b_load000");
        step(1, 0, 1, 1, 12'h000, "b_dn_wrap");

        // Asynchronous reset mid-cycle while counting from 37.
        step(0, 1, 0, 0, 12'h036, "load36");
        step(0, 0, 1, 0, 12'h000, "up37");
        en_a = 1'b1; dir_a = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async.value_a",  {4'h0, value_a}, 12'h000);
        check("async.carry_a",  12'(carry_a),    12'd0);
        check("async.borrow_a", 12'(borrow_a),   12'd0);
        check("async.value_b",  value_b,         12'h000);
        idx_a = 0;
        idx_b = 0;
        @(negedge clk);
        en_a = 1'b0;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 12'h000, "post_rst_hold");
        step(0, 0, 1, 0, 12'h000, "post_rst_up");
        step(0, 0, 1, 0, 12'h000, "post_rst_up2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
